// File: rtl/stopwatch_counter.sv
// stopwatch_counter: up-counting BCD MM:SS stopwatch (00:00 .. 99:59).
// Start/stop, clear and lap-hold are edge-triggered on their rising edges.
// A prescaler produces a one-cycle tick every TICKS_PER_SEC running cycles.
// All outputs are registered, including the four display digits.
module stopwatch_counter #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       at_max
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    // Packed count layout: {min_tens, min_ones, sec_tens, sec_ones}
    localparam logic [15:0] CNT_TOP = 16'h9959;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_MAXED
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    lap_val_q, lap_val_d;
    logic           lap_active_q, lap_active_d;
    logic [15:0]    disp_q, disp_d;
    logic           running_q, running_d;
    logic           at_max_q, at_max_d;
    logic           ss_prev_q, clr_prev_q, lap_prev_q;

    logic           ss_ev, clr_ev, lap_ev;
    logic           tick;
    logic           cnt_at_top;

    // BCD ripple increment of the packed MM:SS value; 99:59 never reaches here.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] so, st, mo, mt;
        so = v[3:0];
        st = v[7:4];
        mo = v[11:8];
        mt = v[15:12];
        if (so != 4'd9) begin
            so = so + 4'd1;
        end else begin
            so = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mo != 4'd9) begin
                    mo = mo + 4'd1;
                end else begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Edge detection, next-state, prescaler, count and lap-hold logic.
    always_comb begin
        ss_ev        = start_stop & ~ss_prev_q;
        clr_ev       = clear & ~clr_prev_q;
        lap_ev       = lap & ~lap_prev_q;
        tick         = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
        cnt_at_top   = (cnt_q == CNT_TOP);

        state_d      = state_q;
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        lap_val_d    = lap_val_q;
        lap_active_d = lap_active_q;

        if (clr_ev) begin
            state_d      = ST_IDLE;
            presc_d      = '0;
            cnt_d        = '0;
            lap_active_d = 1'b0;
        end else begin
            if (state_q == ST_RUNNING) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (tick && !cnt_at_top) begin
                cnt_d = bcd_inc(cnt_q);
            end

            // start_stop outranks lap; a lap in the same cycle is dropped
            if (ss_ev) begin
                case (state_q)
                    ST_IDLE:    state_d = ST_RUNNING;
                    ST_PAUSED:  state_d = ST_RUNNING;
                    ST_RUNNING: state_d = ST_PAUSED;
                    default:    state_d = state_q;
                endcase
            end else if (lap_ev) begin
                if (state_q == ST_RUNNING) begin
                    if (lap_active_q) begin
                        lap_active_d = 1'b0;
                    end else begin
                        lap_active_d = 1'b1;
                        // capture the pre-increment value even if a tick coincides
                        lap_val_d    = cnt_q;
                    end
                end else if (state_q == ST_PAUSED) begin
                    lap_active_d = 1'b0;
                end
            end

            // reaching the top forces the live 99:59 onto the display
            if (tick && cnt_at_top) begin
                state_d      = ST_MAXED;
                lap_active_d = 1'b0;
            end
        end

        // digits follow the current (pre-edge) state, so they lag flags by one cycle
        disp_d    = lap_active_q ? lap_val_q : cnt_q;
        running_d = (state_d == ST_RUNNING);
        at_max_d  = (state_d == ST_MAXED);
    end

    // State, datapath and output registers; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            cnt_q        <= '0;
            lap_val_q    <= '0;
            lap_active_q <= 1'b0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            at_max_q     <= 1'b0;
            // history starts high so a button held through reset is not an event
            ss_prev_q    <= 1'b1;
            clr_prev_q   <= 1'b1;
            lap_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            lap_val_q    <= lap_val_d;
            lap_active_q <= lap_active_d;
            disp_q       <= disp_d;
            running_q    <= running_d;
            at_max_q     <= at_max_d;
            ss_prev_q    <= start_stop;
            clr_prev_q   <= clear;
            lap_prev_q   <= lap;
        end
    end

    assign sec_ones   = disp_q[3:0];
    assign sec_tens   = disp_q[7:4];
    assign min_ones   = disp_q[11:8];
    assign min_tens   = disp_q[15:12];
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign at_max     = at_max_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Testbench for stopwatch_counter: directed scenarios plus random button
// activity, checked every cycle against a seconds-based reference model.
module tb_stopwatch_counter;

    localparam int TPS     = 4;
    localparam int MAX_SEC = 99 * 60 + 59;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_MAX   = 3;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, lap_active, at_max;
    logic [18:0] dut_out;

    int n_checks = 0;
    int n_err    = 0;

    logic [18:0] exp_q[$];

    // reference model state: count held as plain seconds
    int m_mode, m_cnt, m_presc, m_lap_val;
    bit m_lap_act, p_ss, p_clr, p_lap;

    stopwatch_counter #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk),
        .reset(reset),
        .start_stop(start_stop),
        .clear(clear),
        .lap(lap),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .min_tens(min_tens),
        .running(running),
        .lap_active(lap_active),
        .at_max(at_max)
    );

    assign dut_out = {min_tens, min_ones, sec_tens, sec_ones, running, lap_active, at_max};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int mn, sc;
        mn = s / 60;
        sc = s % 60;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_cnt     = 0;
        m_presc   = 0;
        m_lap_val = 0;
        m_lap_act = 0;
        p_ss      = 1;
        p_clr     = 1;
        p_lap     = 1;
    endtask

    // Advance the model across one clock edge and queue the expected outputs.
    task automatic model_step(input bit ss, input bit clr, input bit lp);
        bit e_ss, e_clr, e_lp, tick;
        int old_mode, old_cnt;
        logic [15:0] disp;
        e_ss  = ss && !p_ss;
        e_clr = clr && !p_clr;
        e_lp  = lp && !p_lap;
        p_ss  = ss;
        p_clr = clr;
        p_lap = lp;
        disp  = m_lap_act ? to_bcd(m_lap_val) : to_bcd(m_cnt);
        tick  = (m_mode == M_RUN) && (m_presc == TPS - 1);
        if (e_clr) begin
            m_mode    = M_IDLE;
            m_cnt     = 0;
            m_presc   = 0;
            m_lap_act = 0;
        end else begin
            old_mode = m_mode;
            old_cnt  = m_cnt;
            if (m_mode == M_RUN) m_presc = tick ? 0 : m_presc + 1;
            if (e_ss) begin
                if (old_mode == M_IDLE || old_mode == M_PAUSE) m_mode = M_RUN;
                else if (old_mode == M_RUN) m_mode = M_PAUSE;
            end else if (e_lp) begin
                if (old_mode == M_RUN) begin
                    if (m_lap_act) m_lap_act = 0;
                    else begin
                        m_lap_act = 1;
                        m_lap_val = old_cnt;
                    end
                end else if (old_mode == M_PAUSE) begin
                    m_lap_act = 0;
                end
            end
            if (tick) begin
                if (old_cnt == MAX_SEC) begin
                    m_mode    = M_MAX;
                    m_lap_act = 0;
                end else begin
                    m_cnt = old_cnt + 1;
                end
            end
        end
        exp_q.push_back({disp, (m_mode == M_RUN), m_lap_act, (m_mode == M_MAX)});
    endtask

    task automatic step(input bit ss, input bit clr, input bit lp);
        @(negedge clk);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        model_step(ss, clr, lp);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Sample the outputs just after the edge that follows the last driven step.
    task automatic check_now(input string name, input logic [18:0] exp);
        @(posedge clk);
        #2;
        chk(name, dut_out, exp);
    endtask

    task automatic do_reset(input bit hold_ss);
        @(posedge clk);
        #3;
        reset      = 1'b1;
        start_stop = hold_ss;
        clear      = 1'b0;
        lap        = 1'b0;
        #1;
        chk("async_reset_outputs", dut_out, 19'h0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_step(hold_ss, 0, 0);
    endtask

    task automatic do_clear();
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    // Scoreboard monitor: compares every cycle that has a queued expectation.
    initial begin
        logic [18:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (dut_out !== e) begin
                    n_err++;
                    $display("FAIL scoreboard got=%h expected=%h at %0t", dut_out, e, $time);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_state", dut_out, 19'h0);
        @(negedge clk);
        reset = 1'b0;
        model_step(0, 0, 0);

        // basic run: 10 seconds
        step(1, 0, 0);
        run(41);
        check_now("run_00_10", {16'h0010, 1'b1, 1'b0, 1'b0});

        // pause keeps the partial second
        do_clear();
        step(1, 0, 0);
        run(14);
        step(1, 0, 0);
        run(100);
        check_now("paused_hold", {16'h0003, 1'b0, 1'b0, 1'b0});
        step(1, 0, 0);
        run(1);
        check_now("resume_before", {16'h0003, 1'b1, 1'b0, 1'b0});
        check_now("resume_fraction", {16'h0004, 1'b1, 1'b0, 1'b0});

        // lap freeze and release
        do_clear();
        step(1, 0, 0);
        run(21);
        step(0, 0, 1);
        run(20);
        check_now("lap_frozen", {16'h0005, 1'b1, 1'b1, 1'b0});
        step(0, 0, 1);
        run(1);
        check_now("lap_release", {16'h0010, 1'b1, 1'b0, 1'b0});

        // simultaneous clear/start/lap at 00:07
        do_clear();
        step(1, 0, 0);
        run(29);
        step(1, 1, 1);
        run(1);
        check_now("priority_clear", {16'h0000, 1'b0, 1'b0, 1'b0});
        run(10);
        check_now("priority_no_start", {16'h0000, 1'b0, 1'b0, 1'b0});

        // carries and the 99:59 ceiling
        step(1, 0, 0);
        run(241);
        check_now("carry_01_00", {16'h0100, 1'b1, 1'b0, 1'b0});
        run(2160);
        check_now("carry_10_00", {16'h1000, 1'b1, 1'b0, 1'b0});
        run(21598);
        check_now("top_before_max", {16'h9959, 1'b1, 1'b0, 1'b0});
        check_now("maxed", {16'h9959, 1'b0, 1'b0, 1'b1});
        step(1, 0, 0);
        step(0, 0, 1);
        run(8);
        check_now("maxed_ignores", {16'h9959, 1'b0, 1'b0, 1'b1});
        step(0, 1, 0);
        run(1);
        check_now("maxed_clear", {16'h0000, 1'b0, 1'b0, 1'b0});

        // start_stop held across reset release
        do_reset(1'b1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check_now("held_no_start", {16'h0000, 1'b0, 1'b0, 1'b0});
        step(0, 0, 0);
        step(1, 0, 0);
        check_now("press_after_release", {16'h0000, 1'b1, 1'b0, 1'b0});

        // async reset mid-run
        step(0, 0, 0);
        run(30);
        do_reset(1'b0);
        run(3);
        check_now("idle_after_reset", {16'h0000, 1'b0, 1'b0, 1'b0});

        // random button activity
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 24) == 0);
        end
        run(2);
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
